// File: rtl/hazard_scoreboard_if.sv
// Issue-control bundle between Decode, writeback and the hazard scoreboard.
// master drives the decoded instruction and writeback; slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic              issue;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic              sb_err;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_reg_write, id_mem_read, flush, wb_valid, wb_rd, wb_reg_write,
        input  issue, pc_stall, ifid_stall, idex_bubble, sb_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_reg_write, id_mem_read, flush, wb_valid, wb_rd, wb_reg_write,
        output issue, pc_stall, ifid_stall, idex_bubble, sb_err, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Issue/stall decision for the ID stage of the RV32I pipeline, using per-register
// pending-write counters (x0 untracked) plus a one-entry load-in-EX tracker.
module hazard_scoreboard #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  pend [32];
    logic              ld_ex_valid;
    logic [4:0]        ld_ex_rd;
    logic              sb_err_q;
    logic [PERF_W-1:0] stall_cnt_q;

    logic              wb_write;
    logic              haz_rs1;
    logic              haz_rs2;
    logic              struct_haz;
    logic              stall;
    logic              issue;
    logic [31:0]       inc_vec;
    logic [31:0]       dec_vec;

    assign wb_write = sb.wb_valid & sb.wb_reg_write & (sb.wb_rd != 5'd0);

    always_comb begin
        haz_rs1    = 1'b0;
        haz_rs2    = 1'b0;
        struct_haz = 1'b0;
        inc_vec    = '0;
        dec_vec    = '0;

        if (FWD_EN) begin
            haz_rs1 = sb.id_use_rs1 & (sb.id_rs1 != 5'd0) & ld_ex_valid & (ld_ex_rd == sb.id_rs1);
            haz_rs2 = sb.id_use_rs2 & (sb.id_rs2 != 5'd0) & ld_ex_valid & (ld_ex_rd == sb.id_rs2);
        end else begin
            // A writeback retiring the last pending write releases the source this cycle.
            haz_rs1 = sb.id_use_rs1 & (sb.id_rs1 != 5'd0) & (pend[sb.id_rs1] != CNT_ZERO)
                    & !(wb_write & (sb.wb_rd == sb.id_rs1) & (pend[sb.id_rs1] == CNT_ONE));
            haz_rs2 = sb.id_use_rs2 & (sb.id_rs2 != 5'd0) & (pend[sb.id_rs2] != CNT_ZERO)
                    & !(wb_write & (sb.wb_rd == sb.id_rs2) & (pend[sb.id_rs2] == CNT_ONE));
        end

        struct_haz = sb.id_reg_write & (sb.id_rd != 5'd0) & (pend[sb.id_rd] == CNT_MAX)
                   & !(wb_write & (sb.wb_rd == sb.id_rd));

        stall = sb.id_valid & !sb.flush & (haz_rs1 | haz_rs2 | struct_haz);
        issue = sb.id_valid & !sb.flush & !stall;

        if (issue & sb.id_reg_write & (sb.id_rd != 5'd0)) begin
            inc_vec[sb.id_rd] = 1'b1;
        end
        if (wb_write & (pend[sb.wb_rd] != CNT_ZERO)) begin
            dec_vec[sb.wb_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                pend[r] <= CNT_ZERO;
            end
            ld_ex_valid <= 1'b0;
            ld_ex_rd    <= 5'd0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (inc_vec[r] & !dec_vec[r]) begin
                    pend[r] <= pend[r] + CNT_ONE;
                end else if (dec_vec[r] & !inc_vec[r]) begin
                    pend[r] <= pend[r] - CNT_ONE;
                end
            end
            ld_ex_valid <= issue & sb.id_mem_read & sb.id_reg_write & (sb.id_rd != 5'd0);
            ld_ex_rd    <= sb.id_rd;
            if (wb_write & (pend[sb.wb_rd] == CNT_ZERO)) begin
                sb_err_q <= 1'b1;
            end
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
        end
    end

    assign sb.issue       = issue;
    assign sb.pc_stall    = stall;
    assign sb.ifid_stall  = stall;
    assign sb.idex_bubble = stall | sb.flush;
    assign sb.sb_err      = sb_err_q;
    assign sb.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one forwarding and one conservative instance, each
// checked every cycle against a pending-write-count model, plus directed scenarios.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use1;
        logic       use2;
        logic       rw;
        logic       mr;
        logic       flush;
        logic       wbv;
        logic [4:0] wbrd;
        logic       wbrw;
    } in_t;

    logic clk = 1'b0;
    logic rst;
    in_t  drv [2];
    int   total = 0;
    int   bad   = 0;

    // model state: index 0 = forwarding instance, 1 = conservative instance
    int          pend_m [2][32];
    bit          ld_v   [2];
    logic [4:0]  ld_rd  [2];
    bit          err_m  [2];
    logic [31:0] sc_m   [2];

    logic        o_issue [2];
    logic        o_pcs   [2];
    logic        o_ifs   [2];
    logic        o_bub   [2];
    logic        o_err   [2];
    logic [31:0] o_sc    [2];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.PERF_W(32)) ifa ();
    hazard_scoreboard_if #(.PERF_W(32)) ifc ();

    hazard_scoreboard #(.FWD_EN(1'b1), .CNT_W(2), .PERF_W(32)) dut_f (.clk(clk), .rst(rst), .sb(ifa));
    hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(2), .PERF_W(32)) dut_c (.clk(clk), .rst(rst), .sb(ifc));

    assign ifa.id_valid = drv[0].valid;  assign ifc.id_valid = drv[1].valid;
    assign ifa.id_rs1 = drv[0].rs1;      assign ifc.id_rs1 = drv[1].rs1;
    assign ifa.id_rs2 = drv[0].rs2;      assign ifc.id_rs2 = drv[1].rs2;
    assign ifa.id_rd = drv[0].rd;        assign ifc.id_rd = drv[1].rd;
    assign ifa.id_use_rs1 = drv[0].use1; assign ifc.id_use_rs1 = drv[1].use1;
    assign ifa.id_use_rs2 = drv[0].use2; assign ifc.id_use_rs2 = drv[1].use2;
    assign ifa.id_reg_write = drv[0].rw; assign ifc.id_reg_write = drv[1].rw;
    assign ifa.id_mem_read = drv[0].mr;  assign ifc.id_mem_read = drv[1].mr;
    assign ifa.flush = drv[0].flush;     assign ifc.flush = drv[1].flush;
    assign ifa.wb_valid = drv[0].wbv;    assign ifc.wb_valid = drv[1].wbv;
    assign ifa.wb_rd = drv[0].wbrd;      assign ifc.wb_rd = drv[1].wbrd;
    assign ifa.wb_reg_write = drv[0].wbrw; assign ifc.wb_reg_write = drv[1].wbrw;

    assign o_issue[0] = ifa.issue;       assign o_issue[1] = ifc.issue;
    assign o_pcs[0] = ifa.pc_stall;      assign o_pcs[1] = ifc.pc_stall;
    assign o_ifs[0] = ifa.ifid_stall;    assign o_ifs[1] = ifc.ifid_stall;
    assign o_bub[0] = ifa.idex_bubble;   assign o_bub[1] = ifc.idex_bubble;
    assign o_err[0] = ifa.sb_err;        assign o_err[1] = ifc.sb_err;
    assign o_sc[0] = ifa.stall_cnt;      assign o_sc[1] = ifc.stall_cnt;

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    function automatic bit src_haz(input int m, input bit used, input logic [4:0] s,
                                   input bit wbw, input logic [4:0] wbrd);
        if (!used || s == 5'd0) return 1'b0;
        if (m == 0) return ld_v[m] && (ld_rd[m] == s);
        return (pend_m[m][s] > 0) && !(wbw && wbrd == s && pend_m[m][s] == 1);
    endfunction

    function automatic void model_eval(input int m, output bit st, output bit is, output bit bb);
        in_t d;
        bit  wbw;
        bit  sh;
        d   = drv[m];
        wbw = d.wbv && d.wbrw && (d.wbrd != 5'd0);
        sh  = d.rw && (d.rd != 5'd0) && (pend_m[m][d.rd] >= 3) && !(wbw && d.wbrd == d.rd);
        st  = d.valid && !d.flush &&
              (src_haz(m, d.use1, d.rs1, wbw, d.wbrd) || src_haz(m, d.use2, d.rs2, wbw, d.wbrd) || sh);
        is  = d.valid && !d.flush && !st;
        bb  = st || d.flush;
    endfunction

    function automatic int pick_pending(input int m);
        int start;
        int r;
        start = $urandom_range(1, 31);
        for (int k = 0; k < 31; k++) begin
            r = ((start - 1 + k) % 31) + 1;
            if (pend_m[m][r] > 0) return r;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit   st, is, bb, wbw, dec;
        in_t  d;
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int r = 0; r < 32; r++) pend_m[m][r] = 0;
                ld_v[m] = 1'b0; ld_rd[m] = 5'd0; err_m[m] = 1'b0; sc_m[m] = 32'd0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                model_eval(m, st, is, bb);
                d   = drv[m];
                wbw = d.wbv && d.wbrw && (d.wbrd != 5'd0);
                dec = wbw && (pend_m[m][d.wbrd] > 0);
                if (wbw && pend_m[m][d.wbrd] == 0) err_m[m] = 1'b1;
                if (is && d.rw && d.rd != 5'd0) pend_m[m][d.rd] = pend_m[m][d.rd] + 1;
                if (dec) pend_m[m][d.wbrd] = pend_m[m][d.wbrd] - 1;
                ld_v[m]  = is && d.mr && d.rw && (d.rd != 5'd0);
                ld_rd[m] = d.rd;
                if (st) sc_m[m] = sc_m[m] + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        bit st, is, bb;
        for (int m = 0; m < 2; m++) begin
            model_eval(m, st, is, bb);
            chk1($sformatf("m%0d issue", m), o_issue[m], is);
            chk1($sformatf("m%0d pc_stall", m), o_pcs[m], st);
            chk1($sformatf("m%0d ifid_stall", m), o_ifs[m], st);
            chk1($sformatf("m%0d idex_bubble", m), o_bub[m], bb);
            chk1($sformatf("m%0d sb_err", m), o_err[m], err_m[m]);
            chk32($sformatf("m%0d stall_cnt", m), o_sc[m], sc_m[m]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int m);
        drv[m] = '0;
    endtask

    task automatic instr(input int m, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input bit u1, input bit u2, input bit rw, input bit mr);
        drv[m] = '0;
        drv[m].valid = 1'b1; drv[m].rs1 = rs1; drv[m].rs2 = rs2; drv[m].rd = rd;
        drv[m].use1 = u1; drv[m].use2 = u2; drv[m].rw = rw; drv[m].mr = mr;
    endtask

    task automatic wb(input int m, input logic [4:0] r);
        drv[m].wbv = 1'b1; drv[m].wbrd = r; drv[m].wbrw = 1'b1;
    endtask

    task automatic drain();
        bit busy;
        int r;
        busy = 1'b1;
        for (int i = 0; i < 200 && busy; i++) begin
            cyc();
            busy = 1'b0;
            for (int m = 0; m < 2; m++) begin
                idle(m);
                r = pick_pending(m);
                if (r >= 0) begin
                    wb(m, 5'(r));
                    busy = 1'b1;
                end
            end
        end
        chk1("drain budget", busy, 1'b0);
    endtask

    task automatic rand_step(input int m);
        int r;
        drv[m].valid = ($urandom_range(0, 9) < 8);
        drv[m].rs1   = 5'($urandom_range(0, 7));
        drv[m].rs2   = 5'($urandom_range(0, 7));
        drv[m].rd    = 5'($urandom_range(0, 7));
        drv[m].use1  = ($urandom_range(0, 1) == 1);
        drv[m].use2  = ($urandom_range(0, 1) == 1);
        drv[m].rw    = ($urandom_range(0, 4) != 0);
        drv[m].mr    = ($urandom_range(0, 2) == 0);
        drv[m].flush = ($urandom_range(0, 9) == 0);
        drv[m].wbv = 1'b0; drv[m].wbrd = 5'd0; drv[m].wbrw = 1'b0;
        r = pick_pending(m);
        if (r >= 0 && $urandom_range(0, 9) < 5) begin
            wb(m, 5'(r));
        end else if ($urandom_range(0, 9) == 0) begin
            drv[m].wbv = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
                drv[m].wbrd = 5'd0; drv[m].wbrw = 1'b1;
            end else begin
                drv[m].wbrd = 5'($urandom_range(1, 31)); drv[m].wbrw = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        idle(1);
        #1 rst = 1'b0;
        #3;
        for (int m = 0; m < 2; m++) begin
            chk1("reset issue", o_issue[m], 1'b0);
            chk1("reset pc_stall", o_pcs[m], 1'b0);
            chk1("reset bubble", o_bub[m], 1'b0);
            chk1("reset sb_err", o_err[m], 1'b0);
            chk32("reset stall_cnt", o_sc[m], 32'd0);
        end
        #13 rst = 1'b1;

        // load-use with forwarding: exactly one bubble
        cyc(); instr(0, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
        cyc(); instr(0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0);
        #2;
        chk1("lu issue", o_issue[0], 1'b0);
        chk1("lu pc_stall", o_pcs[0], 1'b1);
        chk1("lu ifid_stall", o_ifs[0], 1'b1);
        chk1("lu bubble", o_bub[0], 1'b1);
        cyc(); #2 chk1("lu issue after bubble", o_issue[0], 1'b1);
        cyc(); idle(0); #2 chk32("lu stall_cnt", o_sc[0], 32'd1);
        drain();

        // conservative RAW: waits until the producer's writeback cycle
        cyc(); instr(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0);
        cyc(); instr(1, 5'd3, 5'd3, 5'd4, 1, 1, 1, 0);
        #2;
        chk1("raw wait issue", o_issue[1], 1'b0);
        chk1("raw wait pc_stall", o_pcs[1], 1'b1);
        cyc(); #2 chk1("raw wait2 issue", o_issue[1], 1'b0);
        cyc(); wb(1, 5'd3); #2 chk1("raw release issue", o_issue[1], 1'b1);
        cyc(); idle(1);
        #2;
        chk32("raw stall_cnt", o_sc[1], 32'd2);
        chk32("model pend x3", 32'(pend_m[1][3]), 32'd0);
        chk32("model pend x4", 32'(pend_m[1][4]), 32'd1);
        drain();

        // counter saturation on x7 and same-cycle writeback release
        for (int k = 0; k < 3; k++) begin
            cyc(); instr(0, 5'd1, 5'd2, 5'd7, 1, 1, 1, 0);
            #2 chk1("x7 write issue", o_issue[0], 1'b1);
        end
        cyc(); #2;
        chk1("struct issue", o_issue[0], 1'b0);
        chk1("struct pc_stall", o_pcs[0], 1'b1);
        cyc(); wb(0, 5'd7); #2 chk1("struct release issue", o_issue[0], 1'b1);
        cyc(); drv[0].wbv = 1'b0; #2 chk1("struct still full", o_issue[0], 1'b0);
        drain();

        // flush during a load-use stall
        cyc(); instr(0, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
        cyc(); instr(0, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0); drv[0].flush = 1'b1;
        #2;
        chk1("flush issue", o_issue[0], 1'b0);
        chk1("flush pc_stall", o_pcs[0], 1'b0);
        chk1("flush bubble", o_bub[0], 1'b1);
        cyc(); idle(0); #2 chk32("flush stall_cnt", o_sc[0], 32'd3);
        drain();

        // stray writeback sets sticky error; x0 is never tracked
        cyc(); idle(0); wb(0, 5'd9);
        cyc(); idle(0); #2 chk1("sb_err set", o_err[0], 1'b1);
        cyc(); cyc(); #2 chk1("sb_err sticky", o_err[0], 1'b1);
        cyc(); instr(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0); instr(0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1);
        #2 chk1("x0 rd issue", o_issue[1], 1'b1);
        cyc(); instr(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 1); wb(1, 5'd0); instr(0, 5'd0, 5'd0, 5'd3, 1, 1, 1, 0);
        #2;
        chk1("x0 src issue", o_issue[1], 1'b1);
        chk1("x0 src pc_stall", o_pcs[1], 1'b0);
        chk1("x0 load-use issue", o_issue[0], 1'b1);
        cyc(); idle(0); idle(1); #2 chk1("x0 wb no err", o_err[1], 1'b0);
        drain();

        // asynchronous reset in the middle of a stall with pend[5]=2
        cyc(); instr(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 0);
        cyc();
        cyc(); instr(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0);
        #2 chk1("pre-reset stall", o_issue[1], 1'b0);
        #1 rst = 1'b0; idle(0); idle(1);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk1("mid reset issue", o_issue[m], 1'b0);
            chk1("mid reset pc_stall", o_pcs[m], 1'b0);
            chk1("mid reset bubble", o_bub[m], 1'b0);
            chk1("mid reset sb_err", o_err[m], 1'b0);
            chk32("mid reset stall_cnt", o_sc[m], 32'd0);
        end
        #2 rst = 1'b1;
        cyc(); instr(1, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0);
        #2;
        chk1("post reset issue", o_issue[1], 1'b1);
        chk1("post reset pc_stall", o_pcs[1], 1'b0);
        cyc(); idle(1);
        drain();

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rand_step(0);
            rand_step(1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
